// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA types, the 640x480@60 timing set and the underrun colour.
package vga_pkg;
  typedef logic [11:0] rgb444_t;
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;
  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;
  localparam vga_timing_t VGA_640X480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam rgb444_t UNDERRUN_RGB = 12'hF0F;
endpackage

// File: rtl/vga_timing_generator_if.sv
// vga_timing_generator_if: ready/valid pixel stream from the framebuffer to the raster generator.
interface vga_timing_generator_if;
  import vga_pkg::*;
  logic pix_valid;
  logic pix_ready;
  rgb444_t pix_data;
  modport master(output pix_valid, pix_data, input pix_ready);
  modport slave(input pix_valid, pix_data, output pix_ready);
endinterface

// File: rtl/vga_testpattern.sv
// vga_testpattern: eight vertical colour bars across the visible line, selected by hcnt.
module vga_testpattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int HW = 10
) (
  input  logic [HW-1:0] hcnt,
  output rgb444_t       rgb
);
  localparam rgb444_t BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                   12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [2:0] bar;
  assign bar = 3'(hcnt / HW'(H_ACTIVE / 8));
  assign rgb = BARS[bar];
endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster timing with a ready/valid pixel input and sticky underrun.
// Optional colour-bar test pattern is built only when VGA_TESTPATTERN_EN is defined.
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640X480_60.h.active,
  parameter int H_FP     = VGA_640X480_60.h.fp,
  parameter int H_SYNC   = VGA_640X480_60.h.sync,
  parameter int H_BP     = VGA_640X480_60.h.bp,
  parameter int V_ACTIVE = VGA_640X480_60.v.active,
  parameter int V_FP     = VGA_640X480_60.v.fp,
  parameter int V_SYNC   = VGA_640X480_60.v.sync,
  parameter int V_BP     = VGA_640X480_60.v.bp,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  vga_timing_generator_if.slave       pix,
  input  logic                        test_en,
  input  logic                        clr_underrun,
  output logic                        underrun,
  output logic                        sof,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hsync,
  output logic                        vga_vsync
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);
  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic pix_en, active, h_last, v_last, hs, vs, tp;
  rgb444_t rgb, rgb_nxt, tp_rgb;
  assign pix_en = div == DW'(CLK_DIV - 1);
  assign h_last = hcnt == HW'(H_TOTAL - 1);
  assign v_last = vcnt == VW'(V_TOTAL - 1);
  assign active = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
  assign hs = hcnt >= HW'(H_ACTIVE + H_FP) && hcnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1) ? HP : ~HP;
  assign vs = vcnt >= VW'(V_ACTIVE + V_FP) && vcnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1) ? VP : ~VP;
`ifdef VGA_TESTPATTERN_EN
  assign tp = test_en;
  vga_testpattern #(.H_ACTIVE(H_ACTIVE), .HW(HW)) u_testpattern (.hcnt(hcnt), .rgb(tp_rgb));
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
  assign tp = 1'b0;
  assign tp_rgb = '0;
`endif
  // The test pattern stalls the stream, so the source never sees a request and no underrun is flagged.
  assign pix.pix_ready = pix_en && active && !tp;
  assign sof = pix_en && hcnt == '0 && vcnt == '0;
  assign rgb_nxt = !active ? '0 : tp ? tp_rgb : pix.pix_valid ? pix.pix_data : UNDERRUN_RGB;
  assign {vga_r, vga_g, vga_b} = rgb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      rgb       <= '0;
      vga_hsync <= ~HP;
      vga_vsync <= ~VP;
      underrun  <= 1'b0;
    end else begin
      div <= pix_en ? '0 : div + 1'b1;
      if (pix_en) begin
        hcnt      <= h_last ? '0 : hcnt + 1'b1;
        vcnt      <= !h_last ? vcnt : v_last ? '0 : vcnt + 1'b1;
        rgb       <= rgb_nxt;
        vga_hsync <= hs;
        vga_vsync <= vs;
      end
      underrun <= (pix.pix_ready && !pix.pix_valid) || (underrun && !clr_underrun);
    end
  end
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: random stream against a cycle-index raster model, plus literal timing pins.
module tb_vga_timing_generator;
  import vga_pkg::*;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3, VA = 8, VF = 2, VS = 2, VB = 3, D = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
`ifdef VGA_TESTPATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, test_en = 1'b0, clr_underrun = 1'b0;
  logic underrun, sof, hsync, vsync;
  logic [3:0] r, g, b;
  int checks = 0, failures = 0;
  int k = 0, mode = 0, clr_mode = 0;
  vga_timing_generator_if pix();
  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(0), .V_POL(0), .CLK_DIV(D)
  ) dut (
    .clk(clk), .rst(rst), .pix(pix), .test_en(test_en), .clr_underrun(clr_underrun),
    .underrun(underrun), .sof(sof), .vga_r(r), .vga_g(g), .vga_b(b),
    .vga_hsync(hsync), .vga_vsync(vsync)
  );
  always #5 clk = ~clk;
  always @(posedge clk) k <= rst ? 0 : k + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask
  // k = clock edges since reset release; pixel index and raster position follow arithmetically.
  function automatic bit pe_at(input int kk); return kk % D == D - 1; endfunction
  function automatic int hx(input int kk); return (kk / D) % HT; endfunction
  function automatic int vy(input int kk); return (kk / D / HT) % VT; endfunction
  function automatic logic [11:0] bar_rgb(input int x);
    case (x / (HA / 8))
      0: return 12'hFFF; 1: return 12'hFF0; 2: return 12'h0FF; 3: return 12'h0F0;
      4: return 12'hF0F; 5: return 12'hF00; 6: return 12'h00F; default: return 12'h000;
    endcase
  endfunction
  logic [11:0] m_rgb;
  logic m_hs, m_vs, m_ur;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rgb", {r, g, b}, 0); chk("rst_hsync", hsync, 1); chk("rst_vsync", vsync, 1);
      chk("rst_ready", pix.pix_ready, 0); chk("rst_sof", sof, 0); chk("rst_underrun", underrun, 0);
      m_rgb = 0; m_hs = 1; m_vs = 1; m_ur = 0;
    end else begin
      bit pe, act, rdy, tpx;
      int x, y;
      pe = pe_at(k); x = hx(k); y = vy(k);
      act = x < HA && y < VA;
      tpx = TP && test_en;
      rdy = pe && act && !tpx;
      chk("ready", pix.pix_ready, rdy);
      chk("sof", sof, pe && x == 0 && y == 0);
      chk("rgb", {r, g, b}, m_rgb);
      chk("hsync", hsync, m_hs);
      chk("vsync", vsync, m_vs);
      chk("underrun", underrun, m_ur);
      if (pe) begin
        m_rgb = !act ? 12'h000 : tpx ? bar_rgb(x) : pix.pix_valid ? pix.pix_data : 12'hF0F;
        m_hs = !(x >= HA + HF && x < HA + HF + HS);
        m_vs = !(y >= VA + VF && y < VA + VF + VS);
      end
      m_ur = (rdy && !pix.pix_valid) || (m_ur && !clr_underrun);
    end
  end
  initial begin
    pix.pix_valid = 1'b0; pix.pix_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mode == 0) begin
        pix.pix_valid = $urandom_range(9, 0) != 0;
        pix.pix_data = 12'($urandom);
        clr_underrun = $urandom_range(15, 0) == 0;
        test_en = TP ? 1'b0 : 1'($urandom);
      end else begin
        pix.pix_valid = mode == 2 || !(pe_at(k) && hx(k) == 10 && vy(k) == 5);
        pix.pix_data = 12'($urandom);
        clr_underrun = clr_mode == 1 || (clr_mode == 2 && pe_at(k) && hx(k) == 10 && vy(k) == 5);
        test_en = mode == 2;
      end
    end
  end
  task automatic wait_sof(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!sof && n < 2000);
    if (!sof) chk("sof_timeout", 0, 1);
  endtask
  // Called on the negedge where sof is high; spans exactly one expected frame.
  task automatic frame_stats();
    int hl = 0, vl = 0, rc = 0, sc = 0, hf = -1, vf = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (!hsync && hf < 0) hf = i;
      if (!vsync && vf < 0) vf = i;
      hl += int'(!hsync); vl += int'(!vsync); rc += int'(pix.pix_ready); sc += int'(sof);
      @(negedge clk);
    end
    chk("sof_period_720", sof, 1); chk("sof_per_frame", sc, 1);
    chk("hsync_low_clks", hl, 90); chk("vsync_low_clks", vl, 96); chk("ready_per_frame", rc, 128);
    chk("hsync_first_low", hf, 37); chk("vsync_first_low", vf, 481);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_sof(n);
    chk("first_sof_clks", n, 2);
    frame_stats();
    mode = 1; clr_mode = 1;
    wait_sof(n);
    clr_mode = 0;
    repeat (261) @(negedge clk);
    chk("drop_10_5_rgb", {r, g, b}, 12'hF0F); chk("drop_10_5_underrun", underrun, 1);
    wait_sof(n);
    clr_mode = 2;
    repeat (261) @(negedge clk);
    chk("set_wins_underrun", underrun, 1); chk("set_wins_clr_seen", clr_underrun, 0);
    clr_mode = 1;
    repeat (2) @(negedge clk);
    chk("clr_underrun", underrun, 0);
    clr_mode = 0;
`ifdef VGA_TESTPATTERN_EN
    mode = 2;
    wait_sof(n);
    wait_sof(n);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("tp_ready", pix.pix_ready, 0);
      if (i == 1) chk("tp_x0", {r, g, b}, 12'hFFF);
      if (i == 5) chk("tp_x2", {r, g, b}, 12'hFF0);
      if (i == 31) chk("tp_x15", {r, g, b}, 12'h000);
    end
`endif
    mode = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(vy(k) == 3 && hx(k) == 8) && n < 2000);
    chk("reach_line3", vy(k), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rgb", {r, g, b}, 0); chk("async_rst_hsync", hsync, 1);
    chk("async_rst_vsync", vsync, 1); chk("async_rst_underrun", underrun, 0);
    chk("async_rst_ready", pix.pix_ready, 0); chk("async_rst_sof", sof, 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_sof(n);
    chk("sof_after_rst_clks", n, 2);
    frame_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
